// File: rtl/learn_guide.sv
// Guided-lesson sequencer: shows the next song note, judges each debounced key press
// against it and keeps hit/wrong/miss scores for the lesson.
module learn_guide #(
   parameter int DEBOUNCE    = 2_000_000,
   parameter int UNIT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] key,
   input  logic [4:0] song_music,
   input  logic [2:0] song_interval,
   output logic [5:0] song_cnt,
   output logic [4:0] expect_note,
   output logic       busy,
   output logic       done,
   output logic       hit,
   output logic       wrong,
   output logic       miss,
   output logic [5:0] hit_cnt,
   output logic [5:0] wrong_cnt,
   output logic [5:0] miss_cnt
);

   localparam int TW = $clog2(7 * UNIT_CYCLES + 1);
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [2:0] IDLE         = 3'd0;
   localparam logic [2:0] FETCH        = 3'd1;
   localparam logic [2:0] WAIT_PRESS   = 3'd2;
   localparam logic [2:0] DEBOUNCE_ST  = 3'd3;
   localparam logic [2:0] WAIT_RELEASE = 3'd4;
   localparam logic [2:0] DONE_ST      = 3'd5;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [TW-1:0] load_val;
   logic [2:0]    units;
   logic [DW-1:0] deb_cnt;
   logic [4:0]    held_key;
   logic          advance;

   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == 6'd63) ? v : v + 6'd1;
   endfunction

   // A zero-length interval still gets one full unit so every note can be played
   assign units    = (song_interval == 3'd0) ? 3'd1 : song_interval;
   assign load_val = TW'(units) * TW'(UNIT_CYCLES);

   assign busy = (state != IDLE) && (state != DONE_ST);
   assign done = (state == DONE_ST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         song_cnt    <= '0;
         expect_note <= '0;
         hit         <= 1'b0;
         wrong       <= 1'b0;
         miss        <= 1'b0;
         hit_cnt     <= '0;
         wrong_cnt   <= '0;
         miss_cnt    <= '0;
         timer       <= '0;
         deb_cnt     <= '0;
         held_key    <= '0;
         advance     <= 1'b0;
      end else begin
         hit   <= 1'b0;
         wrong <= 1'b0;
         miss  <= 1'b0;
         case (state)
            IDLE, DONE_ST: begin
               if (start) begin
                  state       <= FETCH;
                  song_cnt    <= '0;
                  expect_note <= '0;
                  hit_cnt     <= '0;
                  wrong_cnt   <= '0;
                  miss_cnt    <= '0;
                  advance     <= 1'b0;
               end
            end
            FETCH: begin
               if (song_music == 5'd0) begin
                  state       <= DONE_ST;
                  expect_note <= '0;
               end else begin
                  state       <= WAIT_PRESS;
                  expect_note <= song_music;
                  timer       <= load_val;
               end
            end
            WAIT_PRESS: begin
               if (timer <= TW'(1)) begin
                  timer    <= '0;
                  miss     <= 1'b1;
                  miss_cnt <= sat_inc(miss_cnt);
                  advance  <= 1'b1;
                  state    <= WAIT_RELEASE;
               end else begin
                  timer <= timer - TW'(1);
                  if (key != 5'd0) begin
                     held_key <= key;
                     deb_cnt  <= '0;
                     state    <= DEBOUNCE_ST;
                  end
               end
            end
            DEBOUNCE_ST: begin
               // Timeout wins over a debounce that completes on the same cycle
               if (timer <= TW'(1)) begin
                  timer    <= '0;
                  miss     <= 1'b1;
                  miss_cnt <= sat_inc(miss_cnt);
                  advance  <= 1'b1;
                  state    <= WAIT_RELEASE;
               end else begin
                  timer <= timer - TW'(1);
                  if (key != held_key) begin
                     state <= WAIT_PRESS;
                  end else if (deb_cnt == DW'(DEBOUNCE - 1)) begin
                     state <= WAIT_RELEASE;
                     if (held_key == expect_note) begin
                        hit     <= 1'b1;
                        hit_cnt <= sat_inc(hit_cnt);
                        advance <= 1'b1;
                     end else begin
                        wrong     <= 1'b1;
                        wrong_cnt <= sat_inc(wrong_cnt);
                        advance   <= 1'b0;
                     end
                  end else begin
                     deb_cnt <= deb_cnt + DW'(1);
                  end
               end
            end
            WAIT_RELEASE: begin
               // A wrong note retries the same note with whatever time is left
               if (key == 5'd0) begin
                  if (!advance) begin
                     state <= WAIT_PRESS;
                  end else if (song_cnt == 6'd63) begin
                     state       <= DONE_ST;
                     expect_note <= '0;
                  end else begin
                     song_cnt <= song_cnt + 6'd1;
                     state    <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_learn_guide.sv
// Scoreboard bench for learn_guide with a three-entry stub song ROM {13/1, 13/1, end}.
module tb_learn_guide;

   localparam logic [2:0] EV_HIT   = 3'b100;
   localparam logic [2:0] EV_WRONG = 3'b010;
   localparam logic [2:0] EV_MISS  = 3'b001;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [4:0] key   = 5'd0;
   logic [4:0] song_music;
   logic [2:0] song_interval;
   logic [5:0] song_cnt;
   logic [4:0] expect_note;
   logic       busy, done, hit, wrong, miss;
   logic [5:0] hit_cnt, wrong_cnt, miss_cnt;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   learn_guide #(.DEBOUNCE(2), .UNIT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key),
      .song_music(song_music), .song_interval(song_interval),
      .song_cnt(song_cnt), .expect_note(expect_note),
      .busy(busy), .done(done), .hit(hit), .wrong(wrong), .miss(miss),
      .hit_cnt(hit_cnt), .wrong_cnt(wrong_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      song_music    = 5'd0;
      song_interval = 3'd0;
      if (song_cnt < 6'd2) begin
         song_music    = 5'd13;
         song_interval = 3'd1;
      end
   end

   // One clock step; any event pulse is matched against the scoreboard
   task automatic tick();
      logic [2:0] ev;
      logic [2:0] want;
      @(posedge clk);
      #1;
      ev = {hit, wrong, miss};
      if (ev != 3'b000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL event_unexpected got=%b want=none t=%0t", ev, $time);
         end else begin
            want = exp_q.pop_front();
            if (ev !== want) begin
               errors++;
               $display("[TB] FAIL event_order got=%b want=%b t=%0t", ev, want, $time);
            end
         end
      end
   endtask

   task automatic begin_lesson();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic press(input logic [4:0] note, input int cycles);
      key = note;
      repeat (cycles) tick();
      key = 5'd0;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; key = 5'd0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_busy_done got=%b want=00", {busy, done});
      end
      checks++;
      if ({song_cnt, expect_note} !== 11'd0) begin
         errors++; $display("[TB] FAIL reset_cnt_note got=%0d/%0d want=0/0", song_cnt, expect_note);
      end
      checks++;
      if ({hit_cnt, wrong_cnt, miss_cnt, hit, wrong, miss} !== 21'd0) begin
         errors++; $display("[TB] FAIL reset_scores got=%0d/%0d/%0d want=0/0/0", hit_cnt, wrong_cnt, miss_cnt);
      end
   endtask

   task automatic test_two_hits();
      begin_lesson();
      checks++;
      if ({busy, expect_note, song_cnt} !== {1'b1, 5'd13, 6'd0}) begin
         errors++; $display("[TB] FAIL two_hits_first_note got=%b/%0d/%0d want=1/13/0", busy, expect_note, song_cnt);
      end
      exp_q.push_back(EV_HIT);
      press(5'd13, 3);
      tick();
      checks++;
      if (song_cnt !== 6'd1) begin
         errors++; $display("[TB] FAIL two_hits_advance got=%0d want=1", song_cnt);
      end
      tick();
      exp_q.push_back(EV_HIT);
      press(5'd13, 3);
      run_until_done(10);
      checks++;
      if ({done, busy, expect_note, song_cnt} !== {1'b1, 1'b0, 5'd0, 6'd2}) begin
         errors++; $display("[TB] FAIL two_hits_end got=%b%b/%0d/%0d want=10/0/2", done, busy, expect_note, song_cnt);
      end
      checks++;
      if ({hit_cnt, wrong_cnt, miss_cnt} !== {6'd2, 6'd0, 6'd0}) begin
         errors++; $display("[TB] FAIL two_hits_scores got=%0d/%0d/%0d want=2/0/0", hit_cnt, wrong_cnt, miss_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL two_hits_pending got=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_hold();
      begin_lesson();
      checks++;
      if ({hit_cnt, wrong_cnt, miss_cnt, done} !== 19'd0) begin
         errors++; $display("[TB] FAIL hold_restart_clear got=%0d/%0d/%0d done=%b want=0/0/0 done=0", hit_cnt, wrong_cnt, miss_cnt, done);
      end
      exp_q.push_back(EV_HIT);
      key = 5'd13;
      repeat (12) tick();
      checks++;
      if ({hit_cnt, miss_cnt, song_cnt, busy} !== {6'd1, 6'd0, 6'd0, 1'b1}) begin
         errors++; $display("[TB] FAIL hold_single_hit got=%0d/%0d/%0d want=1/0/0", hit_cnt, miss_cnt, song_cnt);
      end
      key = 5'd0;
      exp_q.push_back(EV_MISS);
      tick(); tick();
      repeat (7) tick();
      checks++;
      if (miss_cnt !== 6'd0) begin
         errors++; $display("[TB] FAIL hold_miss_early got=%0d want=0", miss_cnt);
      end
      tick();
      checks++;
      if ({miss, miss_cnt} !== {1'b1, 6'd1}) begin
         errors++; $display("[TB] FAIL hold_miss got=%b/%0d want=1/1", miss, miss_cnt);
      end
      run_until_done(10);
      checks++;
      if ({done, hit_cnt, miss_cnt} !== {1'b1, 6'd1, 6'd1}) begin
         errors++; $display("[TB] FAIL hold_end got=%b/%0d/%0d want=1/1/1", done, hit_cnt, miss_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL hold_pending got=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_wrong();
      begin_lesson();
      exp_q.push_back(EV_WRONG);
      press(5'd12, 3);
      tick();
      checks++;
      if ({wrong_cnt, hit_cnt, song_cnt, expect_note, busy} !== {6'd1, 6'd0, 6'd0, 5'd13, 1'b1}) begin
         errors++; $display("[TB] FAIL wrong_retry got=%0d/%0d/%0d/%0d want=1/0/0/13", wrong_cnt, hit_cnt, song_cnt, expect_note);
      end
      exp_q.push_back(EV_HIT);
      press(5'd13, 3);
      tick(); tick();
      exp_q.push_back(EV_HIT);
      press(5'd13, 3);
      run_until_done(10);
      checks++;
      if ({done, hit_cnt, wrong_cnt, miss_cnt} !== {1'b1, 6'd2, 6'd1, 6'd0}) begin
         errors++; $display("[TB] FAIL wrong_end got=%b/%0d/%0d/%0d want=1/2/1/0", done, hit_cnt, wrong_cnt, miss_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL wrong_pending got=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_timeout();
      begin_lesson();
      for (int n = 0; n < 2; n++) begin
         exp_q.push_back(EV_MISS);
         repeat (7) tick();
         checks++;
         if ({miss, miss_cnt} !== {1'b0, 6'(n)}) begin
            errors++; $display("[TB] FAIL timeout_early got=%b/%0d want=0/%0d", miss, miss_cnt, n);
         end
         tick();
         checks++;
         if ({miss, miss_cnt} !== {1'b1, 6'(n + 1)}) begin
            errors++; $display("[TB] FAIL timeout_pulse got=%b/%0d want=1/%0d", miss, miss_cnt, n + 1);
         end
         tick();
         if (n == 0) begin
            checks++;
            if (song_cnt !== 6'd1) begin
               errors++; $display("[TB] FAIL timeout_advance got=%0d want=1", song_cnt);
            end
            tick();
         end
      end
      run_until_done(10);
      checks++;
      if ({done, song_cnt, hit_cnt} !== {1'b1, 6'd2, 6'd0}) begin
         errors++; $display("[TB] FAIL timeout_end got=%b/%0d/%0d want=1/2/0", done, song_cnt, hit_cnt);
      end
   endtask

   task automatic test_bounce();
      begin_lesson();
      key = 5'd13;
      tick();
      key = 5'd0;
      repeat (4) tick();
      checks++;
      if ({hit_cnt, wrong_cnt, miss_cnt, busy, expect_note} !== {18'd0, 1'b1, 5'd13}) begin
         errors++; $display("[TB] FAIL bounce_ignored got=%0d/%0d/%0d note=%0d want=0/0/0 note=13", hit_cnt, wrong_cnt, miss_cnt, expect_note);
      end
      // Three cycles left on the window: the press completes debounce as time runs out
      exp_q.push_back(EV_MISS);
      press(5'd13, 3);
      tick();
      checks++;
      if ({hit_cnt, miss_cnt, song_cnt} !== {6'd0, 6'd1, 6'd1}) begin
         errors++; $display("[TB] FAIL bounce_timeout_priority got=%0d/%0d/%0d want=0/1/1", hit_cnt, miss_cnt, song_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL bounce_pending got=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      checks++;
      if ({busy, done, song_cnt, miss_cnt} !== 14'd0) begin
         errors++; $display("[TB] FAIL reset_over_start got=%b%b/%0d/%0d want=00/0/0", busy, done, song_cnt, miss_cnt);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_stays_idle got=%b want=0", busy);
      end
      begin_lesson();
      exp_q.push_back(EV_HIT);
      press(5'd13, 3);
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({hit_cnt, song_cnt, expect_note, busy} !== {6'd1, 6'd1, 5'd13, 1'b1}) begin
         errors++; $display("[TB] FAIL busy_start_ignored got=%0d/%0d/%0d want=1/1/13", hit_cnt, song_cnt, expect_note);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({song_cnt, expect_note, busy, done, hit, wrong, miss, hit_cnt, wrong_cnt, miss_cnt} !== 34'd0) begin
         errors++; $display("[TB] FAIL reset_mid got=%0d/%0d busy=%b hit_cnt=%0d want=all zero", song_cnt, expect_note, busy, hit_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL reset_mid_pending got=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_two_hits();
      test_hold();
      test_wrong();
      test_timeout();
      test_bounce();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
